// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - 640x480@60 timing constants, Tetris window defaults, vertical FSM states
package vga_pkg;

    localparam int H_TOTAL = 800;
    localparam int V_TOTAL = 525;
    localparam int H_SYNC  = 96;
    localparam int V_SYNC  = 2;

    localparam int WIN_X0_DEF     = 400;
    localparam int WIN_Y0_DEF     = 143;
    localparam int COLS_DEF       = 16;
    localparam int ROWS_DEF       = 32;
    localparam int SCALE_LOG2_DEF = 3;
    localparam int ADDR_W_DEF     = 9;

    typedef enum logic [1:0] {
        V_IDLE   = 2'd0,
        V_ACTIVE = 2'd1,
        V_DONE   = 2'd2
    } v_state_t;

endpackage

// File: rtl/vga_sync_gen.sv
// rtl/vga_sync_gen.sv - registered hsync/vsync comparators with selectable pulse polarity
module vga_sync_gen #(
    parameter int H_SYNC   = 96,
    parameter int V_SYNC   = 2,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] hcnt,
    input  logic [9:0] vcnt,
    output logic       hsync,
    output logic       vsync
);

    localparam logic       POL    = SYNC_POL;
    localparam logic [9:0] H_LIM  = 10'(H_SYNC);
    localparam logic [9:0] V_LIM  = 10'(V_SYNC);

    always_ff @(posedge clk) begin
        if (rst) begin
            hsync <= ~POL;
            vsync <= ~POL;
        end else begin
            hsync <= (hcnt < H_LIM) ? POL : ~POL;
            vsync <= (vcnt < V_LIM) ? POL : ~POL;
        end
    end

endmodule

// File: rtl/vga_window_addr.sv
// rtl/vga_window_addr.sv - sync, display enable and scaled-window framebuffer address generator
module vga_window_addr #(
    parameter int H_SYNC     = vga_pkg::H_SYNC,
    parameter int V_SYNC     = vga_pkg::V_SYNC,
    parameter bit SYNC_POL   = 1'b0,
    parameter int WIN_X0     = vga_pkg::WIN_X0_DEF,
    parameter int WIN_Y0     = vga_pkg::WIN_Y0_DEF,
    parameter int COLS       = vga_pkg::COLS_DEF,
    parameter int ROWS       = vga_pkg::ROWS_DEF,
    parameter int SCALE_LOG2 = vga_pkg::SCALE_LOG2_DEF,
    parameter int ADDR_W     = vga_pkg::ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [9:0]        hcnt,
    input  logic [9:0]        vcnt,
    input  logic [ADDR_W-1:0] page_base,
    output logic              hsync,
    output logic              vsync,
    output logic              de,
    output logic [ADDR_W-1:0] addr,
    output logic              frame_start
);
    import vga_pkg::*;

    localparam int WIN_W = COLS << SCALE_LOG2;
    localparam int WIN_H = ROWS << SCALE_LOG2;
    localparam int XL    = WIN_X0 + WIN_W - 1;
    localparam int YL    = WIN_Y0 + WIN_H - 1;
    localparam int SW    = (SCALE_LOG2 > 0) ? SCALE_LOG2 : 1;

    localparam logic [SW-1:0]     SUB_LAST = SW'((1 << SCALE_LOG2) - 1);
    localparam logic [ADDR_W-1:0] COLS_A   = ADDR_W'(COLS);
    localparam logic [9:0]        X0_C     = 10'(WIN_X0);
    localparam logic [9:0]        XL_C     = 10'(XL);
    localparam logic [9:0]        Y0_C     = 10'(WIN_Y0);
    localparam logic [9:0]        YL_C     = 10'(YL);

    v_state_t          v_state;
    logic [ADDR_W-1:0] base_l;
    logic [ADDR_W-1:0] row_start;
    logic [SW-1:0]     sub_row;
    logic [SW-1:0]     sub_col;

    logic              fs_hit;
    logic              in_active;
    logic [ADDR_W-1:0] base_next;

    // base_next lets a window starting on line 0 pick up the freshly latched page
    always_comb begin
        fs_hit    = (hcnt == '0) && (vcnt == '0);
        in_active = (v_state == V_ACTIVE);
        base_next = fs_hit ? page_base : base_l;
    end

    vga_sync_gen #(
        .H_SYNC   (H_SYNC),
        .V_SYNC   (V_SYNC),
        .SYNC_POL (SYNC_POL)
    ) u_sync (
        .clk   (clk),
        .rst   (rst),
        .hcnt  (hcnt),
        .vcnt  (vcnt),
        .hsync (hsync),
        .vsync (vsync)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            v_state     <= V_IDLE;
            base_l      <= '0;
            row_start   <= '0;
            sub_row     <= '0;
            sub_col     <= '0;
            de          <= 1'b0;
            addr        <= '0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= fs_hit;
            base_l      <= base_next;

            if ((v_state == V_IDLE || fs_hit) && vcnt == Y0_C && hcnt == '0) begin
                v_state   <= V_ACTIVE;
                row_start <= base_next;
                sub_row   <= '0;
            end else if (fs_hit) begin
                v_state <= V_IDLE;
            end else if (in_active && hcnt == XL_C) begin
                sub_row <= (sub_row == SUB_LAST) ? '0 : sub_row + 1'b1;
                if (sub_row == SUB_LAST) begin
                    row_start <= row_start + COLS_A;
                end
                if (vcnt == YL_C) begin
                    v_state <= V_DONE;
                end
            end

            // addr steps once per cell; outside the window it parks on the frame base
            if (in_active && hcnt == X0_C) begin
                addr    <= row_start;
                sub_col <= '0;
                de      <= 1'b1;
            end else if (in_active && hcnt > X0_C && hcnt <= XL_C) begin
                sub_col <= (sub_col == SUB_LAST) ? '0 : sub_col + 1'b1;
                if (sub_col == SUB_LAST) begin
                    addr <= addr + ADDR_W'(1);
                end
            end else begin
                de   <= 1'b0;
                addr <= base_next;
            end
        end
    end

endmodule

// File: tb/tb_vga_window_addr.sv
// tb/tb_vga_window_addr.sv - scoreboard bench for default and 10x20/scale-16/active-high configurations
module tb_vga_window_addr;

    typedef struct {
        bit         chk;
        bit         rst;
        logic       fs;
        logic       hs1, vs1, de1;
        logic [8:0] a1;
        logic       hs2, vs2, de2;
        logic [8:0] a2;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] hcnt = '0;
    logic [9:0] vcnt = '0;
    logic [8:0] page_base = '0;

    logic       hsync1, vsync1, de1, fs1;
    logic [8:0] addr1;
    logic       hsync2, vsync2, de2, fs2;
    logic [8:0] addr2;

    int checks = 0;
    int errors = 0;

    exp_t sb[$];
    bit         m_ok = 1'b0;
    logic [8:0] m_base = '0;
    int         rst_lo = -1;
    int         rst_hi = -1;
    int         swap_v = -1;
    logic [8:0] swap_val = '0;

    always #5 clk = ~clk;

    vga_window_addr dut1 (
        .clk (clk), .rst (rst), .hcnt (hcnt), .vcnt (vcnt), .page_base (page_base),
        .hsync (hsync1), .vsync (vsync1), .de (de1), .addr (addr1), .frame_start (fs1)
    );

    vga_window_addr #(
        .SYNC_POL (1'b1), .COLS (10), .ROWS (20), .SCALE_LOG2 (4)
    ) dut2 (
        .clk (clk), .rst (rst), .hcnt (hcnt), .vcnt (vcnt), .page_base (page_base),
        .hsync (hsync2), .vsync (vsync2), .de (de2), .addr (addr2), .frame_start (fs2)
    );

    task automatic check(input string tag, input int h, input int v,
                         input logic [8:0] obs, input logic [8:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s h=%0d v=%0d observed=%0d expected=%0d", tag, h, v, obs, expv);
        end
    endtask

    function automatic void exp_win(input int h, input int v, input int x0, input int y0,
                                    input int cols, input int rows, input int s, input logic pol,
                                    output logic hs, output logic vs, output logic de,
                                    output logic [8:0] a);
        int row;
        int col;
        if (rst) begin
            hs = ~pol; vs = ~pol; de = 1'b0; a = '0;
        end else begin
            hs = (h < 96) ? pol : ~pol;
            vs = (v < 2) ? pol : ~pol;
            de = m_ok && v >= y0 && v <= y0 + (rows << s) - 1
                      && h >= x0 && h <= x0 + (cols << s) - 1;
            row = (v - y0) >>> s;
            col = (h - x0) >>> s;
            a = de ? 9'(int'(m_base) + row * cols + col) : '0;
        end
    endfunction

    task automatic step(input int h, input int v, input bit chk);
        exp_t e;
        hcnt = 10'(h);
        vcnt = 10'(v);
        if (rst) begin
            m_ok = 1'b0; m_base = '0;
        end else if (h == 0 && v == 0) begin
            m_ok = 1'b1; m_base = page_base;
        end
        e.chk = chk;
        e.rst = rst;
        e.fs  = !rst && h == 0 && v == 0;
        exp_win(h, v, 400, 143, 16, 32, 3, 1'b0, e.hs1, e.vs1, e.de1, e.a1);
        exp_win(h, v, 400, 143, 10, 20, 4, 1'b1, e.hs2, e.vs2, e.de2, e.a2);
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        if (e.chk) begin
            check("hsync_dflt", h, v, 9'(hsync1), 9'(e.hs1));
            check("vsync_dflt", h, v, 9'(vsync1), 9'(e.vs1));
            check("de_dflt", h, v, 9'(de1), 9'(e.de1));
            check("frame_start_dflt", h, v, 9'(fs1), 9'(e.fs));
            if (e.de1 || e.rst) check("addr_dflt", h, v, addr1, e.a1);
            check("hsync_alt", h, v, 9'(hsync2), 9'(e.hs2));
            check("vsync_alt", h, v, 9'(vsync2), 9'(e.vs2));
            check("de_alt", h, v, 9'(de2), 9'(e.de2));
            check("frame_start_alt", h, v, 9'(fs2), 9'(e.fs));
            if (e.de2 || e.rst) check("addr_alt", h, v, addr2, e.a2);
        end
    endtask

    // Lines away from the checked bands only visit each window's last column,
    // which is all the row counters need to stay in step.
    task automatic run_frame(input int stop_v);
        for (int v = 0; v <= 464; v++) begin
            if (v == stop_v) return;
            if (v == swap_v) page_base = swap_val;
            rst = (v >= rst_lo && v < rst_hi);
            if (v == 0) begin
                for (int h = 0; h < 100; h++) step(h, v, 1'b1);
            end else if (v <= 3) begin
                for (int h = 0; h < 3; h++) step(h, v, 1'b1);
            end else if ((v >= 141 && v <= 161) || (v >= 248 && v <= 262)
                      || (v >= 390 && v <= 400) || (v >= 455 && v <= 464)) begin
                step(0, v, 1'b1);
                for (int h = 398; h <= 562; h++) step(h, v, 1'b1);
            end else if (v >= 143 && v <= 462) begin
                step(527, v, 1'b0);
                step(559, v, 1'b0);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        step(5, 5, 1'b1);
        step(0, 0, 1'b1);
        step(450, 300, 1'b1);
        rst = 1'b0;

        page_base = 9'd0;
        swap_v = 200; swap_val = 9'd256;
        run_frame(-1);
        swap_v = -1;
        run_frame(-1);

        page_base = 9'd0;
        rst_lo = 250; rst_hi = 260;
        run_frame(-1);
        rst_lo = -1; rst_hi = -1;
        run_frame(-1);

        run_frame(160);
        page_base = 9'd128;
        run_frame(-1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
